cisr_channel_mult: RTL and testbench
====================================

// Module: cisr_channel_mult
// PURPOSE
//  Per-channel multiply stage feeding the CISR row accumulator. Pops (value, col_id) entries from a
//  channel's matrix FIFO, fetches vector[col_id] from a 1-cycle sync RAM, multiplies, and pushes each
//  product in order into that channel's mult FIFO. One instance per channel; products emerge in the
//  order their entries were popped.
// PARAMETERS
//  value_size     16   matrix value width (bits)
//  col_id_size     8   column index width; vector RAM depth = 2**col_id_size
//  vec_value_size 16   vector element width
//  mult_size      32   product width written to mult FIFO (>= value_size+vec_value_size)
//  out_depth       4   internal output buffer entries (>= 3; 4 needed for full throughput)
// PORTS
//  clk             in   1                         clock
//  rst             in   1                         synchronous active-high reset
//  in_fifo_data    in   value_size+col_id_size    {value, col_id}; col_id in LSBs; first-word-fall-through
//  in_fifo_empty   in   1                         matrix FIFO empty
//  in_fifo_read    out  1                         pop matrix FIFO this cycle
//  vec_rd_en       out  1                         vector RAM read enable
//  vec_addr        out  col_id_size               vector RAM address
//  vec_data        in   vec_value_size            RAM data, valid cycle after vec_rd_en
//  out_fifo_full   in   1                         mult FIFO full
//  out_fifo_write  out  1                         push product
//  out_fifo_data   out  mult_size                 product
//  idle            out  1                         no entry in flight or buffered
// BEHAVIOUR
//  - One clock, synchronous active-high rst. Reset: in_fifo_read=0, vec_rd_en=0, vec_addr=0,
//    out_fifo_write=0, out_fifo_data=0, idle=1; s1/s2 valid=0, buffer count=0, pointers=0.
//  - Pop (cycle t): in_fifo_read = ~in_fifo_empty & credit_ok, where credit_ok = (buf_count + s1_valid
//    + s2_valid) < out_depth using registered values (drain this cycle not counted). vec_rd_en =
//    in_fifo_read; vec_addr = col_id field of in_fifo_data (combinational from FIFO head).
//  - t+1 (s1): value registered; vec_data valid; product = value * vec_data, registered into s2.
//  - t+2 (s2): product written into out buffer unconditionally (credit guarantees space).
//  - Drain: out_fifo_write = (buf_count != 0) & ~out_fifo_full; out_fifo_data = buffer head
//    (combinational from registered storage). Pop-to-write latency = 3 cycles when unstalled.
//  - s1/s2 never stall: once popped, an entry reaches the buffer. Only pop is throttled.
//  - Buffer: circular, wr/rd pointers wrap mod out_depth; simultaneous write+read leaves count unchanged;
//    writes arriving while full are impossible by construction (assertion in bench).
//  - Throughput: 1 product/cycle sustained when out_fifo_full=0 and in_fifo_empty=0.
//  - Arithmetic: unsigned multiply, zero-extended to mult_size; never truncates.
//  - idle = ~s1_valid & ~s2_valid & (buf_count==0) (registered state only).
//  - rst mid-operation: all in-flight and buffered products discarded; no write in the cycle after rst.
//  - in_fifo_empty bubble: no pop, no RAM read, slot propagates empty; no spurious out_fifo_write.
// CONFIGURATION
//  CISR_MULT_SIGNED_EN defined: value and vec_data treated as two's complement, signed product
//    sign-extended to mult_size. Undefined (default): unsigned multiply, zero-extended.
// TESTING
//  1 Single: vec[5]=7, push {3,5} -> in_fifo_read at t, out_fifo_write=1 data=21 at t+3, idle=1 at t+4.
//  2 Stream: 8 entries col 0..7, vec[i]=i+1, value=2 -> writes 2,4,..,16 on 8 consecutive cycles.
//  3 Backpressure: stream 12 entries, out_fifo_full=1 for cycles 2..11 -> at most 4 pops outstanding,
//    in_fifo_read=0 while credit exhausted, all 12 products delivered in order, none lost/duplicated.
//  4 Width: value=0xFFFF, vec=0xFFFF -> 0xFFFE0001; with CISR_MULT_SIGNED_EN -> 0x00000001;
//    value=0xFFFF, vec=0x0002 signed -> 0xFFFFFFFE.
//  5 Reset mid-stream: rst at cycle 2 of stream with 3 in flight -> next cycle outputs 0, idle=1;
//    after release, new entry {4,1}, vec[1]=5 -> single write of 20.
//  6 Bubbles: in_fifo_empty toggling every cycle over 6 entries -> exactly 6 writes, correct order,
//    out_fifo_write=0 in gap cycles.

Source files
------------

// File: rtl/cisr_channel_mult_if.sv
// Handshake bundle for one CISR multiply channel: matrix FIFO pop side,
// vector RAM read port and mult FIFO push side.
interface cisr_channel_mult_if #(
    parameter int value_size     = 16,
    parameter int col_id_size    = 8,
    parameter int vec_value_size = 16,
    parameter int mult_size      = 32
);
    logic [value_size+col_id_size-1:0] in_fifo_data;
    logic                              in_fifo_empty;
    logic                              in_fifo_read;
    logic                              vec_rd_en;
    logic [col_id_size-1:0]            vec_addr;
    logic [vec_value_size-1:0]         vec_data;
    logic                              out_fifo_full;
    logic                              out_fifo_write;
    logic [mult_size-1:0]              out_fifo_data;

    modport master (
        input  in_fifo_data,
        input  in_fifo_empty,
        output in_fifo_read,
        output vec_rd_en,
        output vec_addr,
        input  vec_data,
        input  out_fifo_full,
        output out_fifo_write,
        output out_fifo_data
    );

    modport slave (
        output in_fifo_data,
        output in_fifo_empty,
        input  in_fifo_read,
        input  vec_rd_en,
        input  vec_addr,
        output vec_data,
        output out_fifo_full,
        input  out_fifo_write,
        input  out_fifo_data
    );
endinterface

// File: rtl/cisr_channel_mult.sv
// CISR per-channel multiply stage: pop {value,col_id}, read vector RAM,
// multiply, buffer, push in order. Define CISR_MULT_SIGNED_EN for signed math.
module cisr_channel_mult #(
    parameter int value_size     = 16,
    parameter int col_id_size    = 8,
    parameter int vec_value_size = 16,
    parameter int mult_size      = 32,
    parameter int out_depth      = 4
) (
    input  logic                clk,
    input  logic                rst,
    cisr_channel_mult_if.master bus,
    output logic                idle
);
    localparam int PW    = value_size + vec_value_size;
    localparam int PTR_W = (out_depth > 1) ? $clog2(out_depth) : 1;
    localparam int CNT_W = $clog2(out_depth + 1);
    localparam int OCC_W = CNT_W + 2;

    logic [value_size-1:0]  w_value;
    logic [col_id_size-1:0] w_col;
    logic [OCC_W-1:0]       w_occ;
    logic                   w_credit_ok;
    logic                   w_pop;
    logic                   w_push;
    logic                   w_drain;
    logic [mult_size-1:0]   w_prod;

    logic                   r_s1_valid;
    logic [value_size-1:0]  r_s1_value;
    logic                   r_s2_valid;
    logic [mult_size-1:0]   r_s2_prod;

    logic [mult_size-1:0]   r_buf [out_depth];
    logic [PTR_W-1:0]       r_wr_ptr;
    logic [PTR_W-1:0]       r_rd_ptr;
    logic [CNT_W-1:0]       r_count;

    function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(out_depth - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign w_value = bus.in_fifo_data[value_size+col_id_size-1 -: value_size];
    assign w_col   = bus.in_fifo_data[col_id_size-1:0];

    // Credit counts every entry already committed to reach the buffer.
    assign w_occ = OCC_W'(r_count) + OCC_W'(r_s1_valid)
                 + OCC_W'(r_s2_valid);
    assign w_credit_ok = w_occ < OCC_W'(out_depth);
    assign w_pop       = ~rst & ~bus.in_fifo_empty & w_credit_ok;

    assign bus.in_fifo_read = w_pop;
    assign bus.vec_rd_en    = w_pop;
    assign bus.vec_addr     = rst ? '0 : w_col;

`ifdef CISR_MULT_SIGNED_EN
    logic signed [PW-1:0] w_prod_full;
    assign w_prod_full = $signed(PW'($signed(r_s1_value)))
                       * $signed(PW'($signed(bus.vec_data)));
    assign w_prod = mult_size'(w_prod_full);
`else
    logic [PW-1:0] w_prod_full;
    assign w_prod_full = PW'(r_s1_value) * PW'(bus.vec_data);
    assign w_prod = mult_size'(w_prod_full);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1_valid <= 1'b0;
            r_s1_value <= '0;
            r_s2_valid <= 1'b0;
            r_s2_prod  <= '0;
        end else begin
            r_s1_valid <= w_pop;
            r_s1_value <= w_value;
            r_s2_valid <= r_s1_valid;
            r_s2_prod  <= w_prod;
        end
    end

    assign w_push  = r_s2_valid;
    assign w_drain = ~rst & (r_count != '0) & ~bus.out_fifo_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < out_depth; i++) begin
                r_buf[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_buf[r_wr_ptr] <= r_s2_prod;
                r_wr_ptr        <= f_inc(r_wr_ptr);
            end
            if (w_drain) begin
                r_rd_ptr <= f_inc(r_rd_ptr);
            end
            unique case ({w_push, w_drain})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign bus.out_fifo_write = w_drain;
    assign bus.out_fifo_data  = r_buf[r_rd_ptr];

    assign idle = ~r_s1_valid & ~r_s2_valid & (r_count == '0);
endmodule

// File: tb/tb_cisr_channel_mult.sv
// Bench for cisr_channel_mult: FIFO/RAM models, scoreboard of expected
// products, per-cycle pop-credit check and directed corner sequences.
`timescale 1ns/1ps
module tb_cisr_channel_mult;
    localparam int VS = 16;
    localparam int CS = 8;
    localparam int XS = 16;
    localparam int MS = 32;
    localparam int OD = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic idle;

    always #5 clk = ~clk;

    cisr_channel_mult_if #(
        .value_size(VS), .col_id_size(CS),
        .vec_value_size(XS), .mult_size(MS)
    ) bus ();

    cisr_channel_mult #(
        .value_size(VS), .col_id_size(CS), .vec_value_size(XS),
        .mult_size(MS), .out_depth(OD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.master),
        .idle(idle)
    );

    typedef struct {
        logic [VS-1:0] v;
        logic [CS-1:0] c;
        logic [XS-1:0] x;
        logic [MS-1:0] e;
    } vec_t;

    logic [VS+CS-1:0] mq[$];
    logic [MS-1:0]    exp_q[$];
    int               pop_cyc_q[$];
    logic [XS-1:0]    vmem [256];

    int cyc = 0, pops = 0, writes = 0, n_chk = 0, n_err = 0;
    int first_wr = -1, last_wr = -1, max_outst = 0;
    bit bubble = 1'b0, lat_chk = 1'b0;
    bit pop_n = 1'b0;
    logic [CS-1:0] addr_n = '0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] expv);
        n_chk++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, expv, cyc);
        end
    endtask

    function automatic logic [MS-1:0] model(input logic [VS-1:0] v,
                                            input logic [XS-1:0] x);
`ifdef CISR_MULT_SIGNED_EN
        logic signed [31:0] a = {{16{v[15]}}, v};
        logic signed [31:0] b = {{16{x[15]}}, x};
        return a * b;
`else
        return {16'b0, v} * {16'b0, x};
`endif
    endfunction

    task automatic drive_fifo();
        bus.in_fifo_empty = (mq.size() == 0) || (bubble && (cyc % 2 == 1));
        bus.in_fifo_data  = (mq.size() != 0) ? mq[0] : '0;
    endtask

    // FIFO pop and 1-cycle RAM model, updated just after the edge
    always @(posedge clk) begin
        cyc++;
        if (pop_n && mq.size() != 0) void'(mq.pop_front());
        #1;
        if (pop_n) bus.vec_data = vmem[addr_n];
        drive_fifo();
    end

    always @(negedge clk) begin
        int outst;
        pop_n  = bus.in_fifo_read;
        addr_n = bus.vec_addr;
        outst  = pops - writes;
        if (!rst) begin
            chk("pop_credit", bus.in_fifo_read,
                !bus.in_fifo_empty && outst < OD);
            chk("rd_en", bus.vec_rd_en, bus.in_fifo_read);
            if (bus.in_fifo_read)
                chk("vec_addr", bus.vec_addr, bus.in_fifo_data[CS-1:0]);
            if (bus.out_fifo_write) begin
                if (exp_q.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL spurious_write: got %0h expected none",
                             bus.out_fifo_data);
                end else begin
                    chk("product", bus.out_fifo_data, exp_q.pop_front());
                end
                if (pop_cyc_q.size() != 0) begin
                    int pc;
                    pc = pop_cyc_q.pop_front();
                    if (lat_chk) chk("latency", cyc - pc, 3);
                end
                writes++;
                if (first_wr < 0) first_wr = cyc;
                last_wr = cyc;
            end
            if (bus.in_fifo_read) begin
                pops++;
                pop_cyc_q.push_back(cyc);
            end
            if (pops - writes > max_outst) max_outst = pops - writes;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push(input logic [VS-1:0] v, input logic [CS-1:0] c,
                        input logic [MS-1:0] e);
        mq.push_back({v, c});
        exp_q.push_back(e);
        drive_fifo();
    endtask

    task automatic wait_idle(input string nm);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (mq.size() == 0 && exp_q.size() == 0 && idle) begin
                ok = 1'b1;
                break;
            end
        end
        chk(nm, ok, 1'b1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tv[7];
        int w0;
        bit got;

        tv[0] = '{16'd3, 8'd5, 16'd7, 32'd21};
`ifdef CISR_MULT_SIGNED_EN
        tv[1] = '{16'hFFFF, 8'd9, 16'hFFFF, 32'h0000_0001};
        tv[2] = '{16'hFFFF, 8'd10, 16'h0002, 32'hFFFF_FFFE};
        tv[5] = '{16'h7FFF, 8'd14, 16'h8000, 32'hC000_8000};
`else
        tv[1] = '{16'hFFFF, 8'd9, 16'hFFFF, 32'hFFFE_0001};
        tv[2] = '{16'hFFFF, 8'd10, 16'h0002, 32'h0001_FFFE};
        tv[5] = '{16'h7FFF, 8'd14, 16'h8000, 32'h3FFF_8000};
`endif
        tv[3] = '{16'd0, 8'd11, 16'd1234, 32'd0};
        tv[4] = '{16'h8000, 8'd12, 16'h8000, 32'h4000_0000};
        tv[6] = '{16'd100, 8'd255, 16'd200, 32'd20000};

        for (int i = 0; i < 256; i++) vmem[i] = '0;
        bus.vec_data      = '0;
        bus.out_fifo_full = 1'b0;
        drive_fifo();

        repeat (3) tick();
        chk("rst_read", bus.in_fifo_read, 1'b0);
        chk("rst_rd_en", bus.vec_rd_en, 1'b0);
        chk("rst_addr", bus.vec_addr, 8'd0);
        chk("rst_write", bus.out_fifo_write, 1'b0);
        chk("rst_data", bus.out_fifo_data, 32'd0);
        chk("rst_idle", idle, 1'b1);
        rst = 1'b0;
        tick();

        // single entries, full latency and idle return
        lat_chk = 1'b1;
        for (int i = 0; i < 7; i++) begin
            vmem[tv[i].c] = tv[i].x;
            w0 = writes;
            push(tv[i].v, tv[i].c, tv[i].e);
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                tick();
                if (writes != w0) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("single_write", got, 1'b1);
            chk("single_idle", idle, 1'b1);
        end

        // back-to-back stream
        for (int i = 0; i < 8; i++) vmem[i] = XS'(i + 1);
        w0 = writes;
        first_wr = -1;
        for (int i = 0; i < 8; i++)
            push(16'd2, CS'(i), model(16'd2, XS'(i + 1)));
        wait_idle("stream_done");
        chk("stream_count", writes - w0, 8);
        chk("stream_span", last_wr - first_wr, 7);

        // backpressure
        lat_chk = 1'b0;
        max_outst = 0;
        for (int i = 0; i < 12; i++) vmem[i] = XS'(i * 3 + 1);
        w0 = writes;
        for (int i = 0; i < 12; i++)
            push(VS'(i + 10), CS'(i), model(VS'(i + 10), XS'(i * 3 + 1)));
        repeat (2) tick();
        bus.out_fifo_full = 1'b1;
        repeat (10) tick();
        bus.out_fifo_full = 1'b0;
        wait_idle("bp_done");
        chk("bp_count", writes - w0, 12);
        chk("bp_max_outst", max_outst, OD);

        // reset with three entries in flight
        for (int i = 0; i < 8; i++) vmem[i] = XS'(i + 100);
        for (int i = 0; i < 6; i++)
            push(16'd9, CS'(i), model(16'd9, XS'(i + 100)));
        repeat (3) tick();
        chk("pre_rst_busy", idle, 1'b0);
        rst = 1'b1;
        mq.delete();
        exp_q.delete();
        pop_cyc_q.delete();
        pops = 0;
        writes = 0;
        drive_fifo();
        tick();
        chk("mid_rst_write", bus.out_fifo_write, 1'b0);
        chk("mid_rst_data", bus.out_fifo_data, 32'd0);
        chk("mid_rst_idle", idle, 1'b1);
        rst = 1'b0;
        tick();
        chk("post_rst_write", bus.out_fifo_write, 1'b0);
        chk("post_rst_idle", idle, 1'b1);
        vmem[1] = 16'd5;
        w0 = writes;
        lat_chk = 1'b1;
        push(16'd4, 8'd1, 32'd20);
        wait_idle("post_rst_done");
        chk("post_rst_count", writes - w0, 1);

        // bubbles on every other cycle
        for (int i = 0; i < 6; i++) vmem[20 + i] = XS'(i + 7);
        bubble = 1'b1;
        first_wr = -1;
        w0 = writes;
        for (int i = 0; i < 6; i++)
            push(VS'(i + 1), CS'(20 + i), model(VS'(i + 1), XS'(i + 7)));
        wait_idle("bubble_done");
        bubble = 1'b0;
        drive_fifo();
        chk("bubble_count", writes - w0, 6);
        chk("bubble_span", last_wr - first_wr, 10);

        repeat (3) tick();
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
